// File: rtl/dmem_arbiter.sv
// Data-memory arbiter/sequencer: shares one memory port between core load/store and a loader.
// Optional grant/stall statistics counters are compiled in with DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk1,
   input  logic              reset1,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]       stat_core_grants,
   output logic [31:0]       stat_ldr_grants,
   output logic [31:0]       stat_stall_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, RD_CORE, RD_LDR} state_e;

   state_e            state_q, state_d;
   logic [2:0]        lat_cnt_q, lat_cnt_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
   logic              core_win, ldr_win, core_done;

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      core_rdata_d = core_rdata_q;
      ldr_rdata_d  = ldr_rdata_q;
      core_win     = 1'b0;
      ldr_win      = 1'b0;
      core_done    = 1'b0;
      ldr_gnt      = 1'b0;
      ldr_rvalid   = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_q)
         IDLE: begin
            // Issue is gated by reset so the memory port stays quiet while reset is held.
            if (reset1) begin
               if (ldr_req && (!core_req || starve_cnt_q == 4'(STARVE_LIMIT)))
                  ldr_win = 1'b1;
               else if (core_req)
                  core_win = 1'b1;
            end
            if (core_win) begin
               mem_en    = 1'b1;
               mem_we    = core_we;
               mem_addr  = core_addr;
               mem_wdata = core_wdata;
               if (core_we) core_done = 1'b1;
               else begin
                  state_d   = RD_CORE;
                  lat_cnt_d = 3'(MEM_LATENCY);
               end
            end
            if (ldr_win) begin
               ldr_gnt   = 1'b1;
               mem_en    = 1'b1;
               mem_we    = ldr_we;
               mem_addr  = ldr_addr;
               mem_wdata = ldr_wdata;
               if (!ldr_we) begin
                  state_d   = RD_LDR;
                  lat_cnt_d = 3'(MEM_LATENCY);
               end
            end
         end
         RD_CORE, RD_LDR: begin
            lat_cnt_d = lat_cnt_q - 3'd1;
            if (lat_cnt_q == 3'd1) begin
               state_d = IDLE;
               if (state_q == RD_CORE) begin
                  core_done    = 1'b1;
                  core_rdata_d = mem_rdata;
               end else begin
                  ldr_rvalid  = 1'b1;
                  ldr_rdata_d = mem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (ldr_gnt || !ldr_req)
         starve_cnt_d = '0;
      else if (core_win && starve_cnt_q != 4'(STARVE_LIMIT))
         starve_cnt_d = starve_cnt_q + 4'd1;
   end

   // Read data is forwarded in the capture cycle so the core can write back as stall drops.
   assign core_rdata = core_rdata_d;
   assign ldr_rdata  = ldr_rdata_d;
   assign core_stall = core_req & ~core_done;

   always_ff @(posedge clk1 or negedge reset1) begin
      if (!reset1) begin
         state_q      <= IDLE;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
         core_rdata_q <= '0;
         ldr_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         core_rdata_q <= core_rdata_d;
         ldr_rdata_q  <= ldr_rdata_d;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_core_q, stat_core_d, stat_ldr_q, stat_ldr_d, stat_stall_q, stat_stall_d;

   always_comb begin
      stat_core_d  = stat_core_q;
      stat_ldr_d   = stat_ldr_q;
      stat_stall_d = stat_stall_q;
      if (core_win && stat_core_q != '1) stat_core_d = stat_core_q + 32'd1;
      if (ldr_gnt && stat_ldr_q != '1) stat_ldr_d = stat_ldr_q + 32'd1;
      if (core_stall && stat_stall_q != '1) stat_stall_d = stat_stall_q + 32'd1;
   end

   always_ff @(posedge clk1 or negedge reset1) begin
      if (!reset1) begin
         stat_core_q  <= '0;
         stat_ldr_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_core_q  <= stat_core_d;
         stat_ldr_q   <= stat_ldr_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_core_grants  = stat_core_q;
   assign stat_ldr_grants   = stat_ldr_q;
   assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Data-memory arbiter and access sequencer for the single-cycle RV32I core. It shares the one data-memory port between the core's load/store path and a loader/debug requester. It sequences multi-cycle reads, and it stalls the core PC while a core access is pending. It sits between the core's ALU-result/store-data path and the data memory, alongside the PC stall input.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from read issue (mem_en & ~mem_we) to mem_rdata valid; legal range 1..7
- STARVE_LIMIT, 4, consecutive core grants with loader waiting before loader is forced through; legal range 1..15

Ports:
- clk1  in  1  clock, rising edge
- reset1  in  1  reset, asynchronous, active-low
- core_req  in  1  core access request (load or store instruction)
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  byte address (ALU result)
- core_wdata  in  DATA_W  store data
- core_rdata  out  DATA_W  load data, held until next core read completes
- core_stall  out  1  freeze PC/writeback while high
- ldr_req  in  1  loader request; held until ldr_gnt
- ldr_we  in  1  loader write enable
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_gnt  out  1  one-cycle pulse: loader request issued to memory
- ldr_rvalid  out  1  one-cycle pulse: ldr_rdata valid
- ldr_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after read issue

## Operation
- FSM states: IDLE, RD_CORE, RD_LDR. At most one read is outstanding at a time. Writes never leave IDLE.
- Arbitration happens only in IDLE. The core wins by default. The loader wins when core_req=0, or when starve_cnt == STARVE_LIMIT.
- starve_cnt (4 bit):
  - Increments on each core grant while ldr_req=1.
  - Clears on ldr_gnt or when ldr_req=0.
  - Saturates at STARVE_LIMIT.
- Issue cycle: mem_en=1, and mem_we/addr/wdata are driven combinationally from the winner.
  - Write: completes in the issue cycle. For the core, core_stall=0 that cycle.
  - Read: the FSM moves to RD_CORE or RD_LDR and loads lat_cnt=MEM_LATENCY.
- In RD_*, lat_cnt decrements each cycle. At lat_cnt==1, mem_rdata is captured:
  - For the core: into core_rdata, with core_stall deasserted that cycle.
  - For the loader: into ldr_rdata, with ldr_rvalid pulsed.
  - The FSM returns to IDLE on the next edge.
- core_stall = core_req & ~core_done. core_done is high only in a core write issue cycle or a core read capture cycle.
- A core_req arriving while in RD_LDR stalls the core until the loader read finishes and the core is then granted.
- mem_en=0 in RD_* states. No new access issues until return to IDLE.

## Timing
- Reset values (async on reset1 low):
  - state=IDLE, starve_cnt=0, lat_cnt=0
  - core_rdata=0, ldr_rdata=0
  - ldr_gnt=0, ldr_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - core_stall follows core_req while in reset.
- Uncontended core write: 0 stall cycles. Uncontended core read: MEM_LATENCY stall cycles, with data at the end of stall.
- Back-to-back reads: issue-to-issue spacing is MEM_LATENCY+1 cycles.
- Simultaneous core_req and ldr_req in IDLE: core granted unless starve_cnt==STARVE_LIMIT.
- Reset asserted mid-read: the outstanding read is abandoned, and a late mem_rdata is ignored. After deassertion the FSM starts from IDLE.
- Requesters must hold req/we/addr/wdata stable until completion (core) or ldr_gnt (loader). Changes before then are undefined.

## Configuration
- DMEM_ARB_STATS_EN defined:
  - Adds outputs stat_core_grants, stat_ldr_grants and stat_stall_cycles, each 32 bit, saturating at 0xFFFFFFFF, reset to 0.
  - stat_stall_cycles counts cycles with core_stall=1.
- Undefined: these outputs and their counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Core store, addr 0x40, data 0xDEADBEEF, no loader: mem_en=mem_we=1 same cycle, core_stall=0 throughout.
- Core load from 0x40, MEM_LATENCY=2, memory returns 0xDEADBEEF: core_stall high 2 cycles, core_rdata=0xDEADBEEF in the cycle stall drops.
- core_req and ldr_req both held high, STARVE_LIMIT=4, core reads: 4 core grants, then ldr_gnt pulses, then the core resumes; starve_cnt returns to 0.
- Loader read of 0x100 in progress (RD_LDR), core_req raised: core_stall=1 until ldr_rvalid, then the core read issues the next cycle.
- reset1 pulsed low during RD_CORE: all outputs reach reset values immediately, no ldr_rvalid or core completion, and a clean core write succeeds after release.
- With DMEM_ARB_STATS_EN, after scenario 3 run for 10 arbitrations: stat_core_grants + stat_ldr_grants = 10, and stat_stall_cycles matches the bench-counted stall cycles.
